// File: rtl/time_of_day_counter.sv
// BCD time-of-day counter: hh:mm:ss with run/set modes,
// 12/24-hour display mapping and a day-rollover pulse.
module time_of_day_counter #(
  parameter int PRESCALE = 1,
  parameter int PRE_W    = 10
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       tick,
  input  logic       run,
  input  logic       up_down,
  input  logic [1:0] sel,
  input  logic       inc,
  input  logic       dec,
  input  logic       mode12,
  output logic [3:0] sec_u,
  output logic [2:0] sec_t,
  output logic [3:0] min_u,
  output logic [2:0] min_t,
  output logic [3:0] hr_u,
  output logic [1:0] hr_t,
  output logic       pm,
  output logic       day_pulse
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [3:0]       hr_u_q;
  logic [1:0]       hr_t_q;
  logic             step;
  logic             set_ev;
  logic             dir;
  logic [8:0]       s_nx;
  logic [8:0]       m_nx;
  logic [8:0]       h_nx;
  logic             unused_nx;

  // Returns {wrap, tens, units}; wrap flags max->0 going up or 0->max going down.
  function automatic logic [8:0] bcd_step(
    input logic       up,
    input logic [3:0] t,
    input logic [3:0] u,
    input logic [3:0] mt,
    input logic [3:0] mu
  );
    logic [8:0] r;
    if (up) begin
      if (t == mt && u == mu)
        r = 9'h100;
      else if (u == 4'd9)
        r = {1'b0, t + 4'd1, 4'd0};
      else
        r = {1'b0, t, u + 4'd1};
    end else begin
      if (t == 4'd0 && u == 4'd0)
        r = {1'b1, mt, mu};
      else if (u == 4'd0)
        r = {1'b0, t - 4'd1, 4'd9};
      else
        r = {1'b0, t, u - 4'd1};
    end
    return r;
  endfunction

  assign step   = run && tick && (pre_cnt == PRE_LAST);
  assign set_ev = !run && (inc ^ dec);
  assign dir    = run ? up_down : inc;

  assign s_nx = bcd_step(dir, {1'b0, sec_t}, sec_u, 4'd5, 4'd9);
  assign m_nx = bcd_step(dir, {1'b0, min_t}, min_u, 4'd5, 4'd9);
  assign h_nx = bcd_step(dir, {2'b0, hr_t_q}, hr_u_q, 4'd2, 4'd3);

  assign unused_nx = ^{s_nx[7], m_nx[7], h_nx[7:6]};

  always_ff @(posedge clk_out) begin
    if (reset) begin
      sec_u     <= '0;
      sec_t     <= '0;
      min_u     <= '0;
      min_t     <= '0;
      hr_u_q    <= '0;
      hr_t_q    <= '0;
      pre_cnt   <= '0;
      day_pulse <= 1'b0;
    end else begin
      day_pulse <= 1'b0;
      if (!run)
        pre_cnt <= '0;
      else if (tick)
        pre_cnt <= step ? '0 : pre_cnt + PRE_W'(1);
      if (step) begin
        {sec_t, sec_u} <= s_nx[6:0];
        if (s_nx[8])
          {min_t, min_u} <= m_nx[6:0];
        if (s_nx[8] && m_nx[8])
          {hr_t_q, hr_u_q} <= h_nx[5:0];
        day_pulse <= s_nx[8] && m_nx[8] && h_nx[8];
      end else if (set_ev) begin
        // Set mode wraps inside the chosen field only.
        unique case (sel)
          2'd0:    {sec_t, sec_u} <= s_nx[6:0];
          2'd1:    {min_t, min_u} <= m_nx[6:0];
          2'd2:    {hr_t_q, hr_u_q} <= h_nx[5:0];
          default: ;
        endcase
      end
    end
  end

  assign pm = (hr_t_q == 2'd2) ||
              (hr_t_q == 2'd1 && hr_u_q >= 4'd2);

  always_comb begin
    hr_t = hr_t_q;
    hr_u = hr_u_q;
    if (mode12) begin
      unique case (1'b1)
        (hr_t_q == 2'd0 && hr_u_q == 4'd0): begin
          hr_t = 2'd1;
          hr_u = 4'd2;
        end
        (hr_t_q == 2'd1 && hr_u_q >= 4'd3): begin
          hr_t = 2'd0;
          hr_u = hr_u_q - 4'd2;
        end
        (hr_t_q == 2'd2 && hr_u_q <= 4'd1): begin
          hr_t = 2'd0;
          hr_u = hr_u_q + 4'd8;
        end
        (hr_t_q == 2'd2 && hr_u_q >= 4'd2): begin
          hr_t = 2'd1;
          hr_u = hr_u_q - 4'd2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: PRESCALE=1 and PRESCALE=4 instances
// checked every cycle against a seconds-of-day reference model.
module tb_time_of_day_counter;

  logic       clk_out = 1'b0;
  logic       reset   = 1'b1;
  logic       tick    = 1'b0;
  logic       run     = 1'b0;
  logic       up_down = 1'b1;
  logic [1:0] sel     = 2'd3;
  logic       inc     = 1'b0;
  logic       dec     = 1'b0;
  logic       mode12  = 1'b0;

  logic [3:0] su [2];
  logic [2:0] st [2];
  logic [3:0] mu [2];
  logic [2:0] mt [2];
  logic [3:0] hu [2];
  logic [1:0] ht [2];
  logic       pm_o [2];
  logic       dp_o [2];

  int secs  [2];
  int pre   [2];
  int pulse [2];
  int checks = 0;
  int errors = 0;

  always #5 clk_out = ~clk_out;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    time_of_day_counter #(
      .PRESCALE(g == 0 ? 1 : 4),
      .PRE_W   (10)
    ) dut (
      .clk_out  (clk_out),
      .reset    (reset),
      .tick     (tick),
      .run      (run),
      .up_down  (up_down),
      .sel      (sel),
      .inc      (inc),
      .dec      (dec),
      .mode12   (mode12),
      .sec_u    (su[g]),
      .sec_t    (st[g]),
      .min_u    (mu[g]),
      .min_t    (mt[g]),
      .hr_u     (hu[g]),
      .hr_t     (ht[g]),
      .pm       (pm_o[g]),
      .day_pulse(dp_o[g])
    );
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int h, m, s, d, p;
    p = (k == 0) ? 1 : 4;
    if (reset) begin
      secs[k]  = 0;
      pre[k]   = 0;
      pulse[k] = 0;
      return;
    end
    pulse[k] = 0;
    if (run) begin
      if (tick) begin
        if (pre[k] == p - 1) begin
          pre[k] = 0;
          if (up_down) begin
            pulse[k] = (secs[k] == 86399) ? 1 : 0;
            secs[k]  = (secs[k] + 1) % 86400;
          end else begin
            pulse[k] = (secs[k] == 0) ? 1 : 0;
            secs[k]  = (secs[k] + 86399) % 86400;
          end
        end else begin
          pre[k]++;
        end
      end
    end else begin
      pre[k] = 0;
      if (inc != dec) begin
        h = secs[k] / 3600;
        m = (secs[k] / 60) % 60;
        s = secs[k] % 60;
        d = inc ? 1 : -1;
        case (sel)
          2'd0: s = (s + d + 60) % 60;
          2'd1: m = (m + d + 60) % 60;
          2'd2: h = (h + d + 24) % 24;
          default: ;
        endcase
        secs[k] = h * 3600 + m * 60 + s;
      end
    end
  endtask

  task automatic compare(input int k);
    int h, m, s, hd;
    logic [19:0] e, g;
    h  = secs[k] / 3600;
    m  = (secs[k] / 60) % 60;
    s  = secs[k] % 60;
    hd = h;
    if (mode12) hd = (h % 12 == 0) ? 12 : h % 12;
    e = {2'(hd / 10), 4'(hd % 10), 3'(m / 10), 4'(m % 10),
         3'(s / 10), 4'(s % 10)};
    g = {ht[k], hu[k], mt[k], mu[k], st[k], su[k]};
    check($sformatf("time%0d", k), 32'(g), 32'(e));
    check($sformatf("pm%0d", k), 32'(pm_o[k]), 32'(h >= 12));
    check($sformatf("day_pulse%0d", k), 32'(dp_o[k]), 32'(pulse[k]));
  endtask

  task automatic cyc();
    @(posedge clk_out);
    model_step(0);
    model_step(1);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic setp(input logic [1:0] s, input logic i,
                      input logic d, input int n);
    run = 1'b0;
    sel = s;
    repeat (n) begin
      inc = i;
      dec = d;
      cyc();
    end
    inc = 1'b0;
    dec = 1'b0;
  endtask

  task automatic ticks(input logic ud, input int n);
    run     = 1'b1;
    up_down = ud;
    repeat (n) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    cyc();
    do_reset();

    // count up through the first minute
    ticks(1'b1, 59);
    ticks(1'b1, 1);

    // 23:59:58 -> up rollover
    do_reset();
    setp(2'd2, 1'b0, 1'b1, 1);
    setp(2'd1, 1'b0, 1'b1, 1);
    setp(2'd0, 1'b0, 1'b1, 2);
    ticks(1'b1, 1);
    ticks(1'b1, 1);

    // down rollover
    do_reset();
    ticks(1'b0, 1);
    ticks(1'b0, 1);

    // set mode field isolation at 10:59:30
    do_reset();
    setp(2'd2, 1'b1, 1'b0, 10);
    setp(2'd1, 1'b0, 1'b1, 1);
    setp(2'd0, 1'b0, 1'b1, 30);
    setp(2'd1, 1'b1, 1'b0, 1);
    setp(2'd1, 1'b0, 1'b1, 1);
    setp(2'd1, 1'b1, 1'b1, 1);
    setp(2'd3, 1'b1, 1'b0, 1);
    run = 1'b1;
    inc = 1'b1;
    cyc();
    inc = 1'b0;

    // display mapping across all hours
    do_reset();
    for (int h = 0; h < 24; h++) begin
      mode12 = 1'b1;
      cyc();
      mode12 = 1'b0;
      cyc();
      setp(2'd2, 1'b1, 1'b0, 1);
    end

    // prescaler restart and reset priority
    do_reset();
    ticks(1'b1, 3);
    ticks(1'b1, 1);
    ticks(1'b1, 2);
    setp(2'd3, 1'b0, 1'b0, 1);
    ticks(1'b1, 4);
    run   = 1'b1;
    tick  = 1'b1;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tick  = 1'b0;
    cyc();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 299) == 0);
      run    = ($urandom_range(0, 9) != 0);
      tick   = 1'($urandom);
      if ($urandom_range(0, 49) == 0) up_down = ~up_down;
      sel    = 2'($urandom);
      inc    = ($urandom_range(0, 3) == 0);
      dec    = ($urandom_range(0, 3) == 0);
      mode12 = 1'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
